// File: rtl/uart_rx_oversample_voter_pkg.sv
// rtl/uart_rx_oversample_voter_pkg.sv - shared types and window helpers for the UART RX sampler
package uart_rx_pkg;

  typedef enum logic {SAMP_MAJORITY, SAMP_SINGLE} samp_mode_e;

  localparam int unsigned PRESCALE_WIDTH_DEF = 6;

  function automatic int unsigned maj_half(input int unsigned n);
    return (n - 1) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_oversample_voter_if.sv
// rtl/uart_rx_oversample_voter_if.sv - RX FSM to data-sampler signal bundle
interface uart_rx_oversample_voter_if
  import uart_rx_pkg::*;
#(
  parameter int unsigned PRESCALE_WIDTH = PRESCALE_WIDTH_DEF
);
  logic                      RX_IN;
  logic [PRESCALE_WIDTH-1:0] PRESCALE;
  logic [PRESCALE_WIDTH-1:0] EDG_CNT;
  logic                      DAT_SAMP_EN;
  logic                      SAMP_MODE;
  logic                      SAMPLED_BIT;
  logic                      SAMPLE_VALID;
  logic                      NOISE_FLAG;
  logic                      CFG_ERR;

  modport master (
    output RX_IN, PRESCALE, EDG_CNT, DAT_SAMP_EN, SAMP_MODE,
    input  SAMPLED_BIT, SAMPLE_VALID, NOISE_FLAG, CFG_ERR
  );

  modport slave (
    input  RX_IN, PRESCALE, EDG_CNT, DAT_SAMP_EN, SAMP_MODE,
    output SAMPLED_BIT, SAMPLE_VALID, NOISE_FLAG, CFG_ERR
  );
endinterface

// File: rtl/uart_rx_oversample_voter_sample_window.sv
// rtl/uart_rx_oversample_voter_sample_window.sv - sample window bounds and legality around the bit centre
module uart_rx_sample_window
  import uart_rx_pkg::*;
#(
  parameter int unsigned PRESCALE_WIDTH = PRESCALE_WIDTH_DEF,
  parameter int unsigned NUM_SAMPLES    = 3
) (
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      samp_single,
  output logic [PRESCALE_WIDTH:0]   first,
  output logic [PRESCALE_WIDTH:0]   last,
  output logic                      cfg_err,
  output logic                      single
);
  localparam int unsigned W1 = PRESCALE_WIDTH + 1;
  localparam logic [PRESCALE_WIDTH:0] HALF = W1'(maj_half(NUM_SAMPLES));

  logic [PRESCALE_WIDTH:0] pre_ext;
  logic [PRESCALE_WIDTH:0] center;

  assign pre_ext = {1'b0, prescale};
  assign center  = pre_ext >> 1;

  // LAST > PRESCALE-1 is tested as LAST >= PRESCALE so PRESCALE=0 cannot wrap.
  assign cfg_err = (center < HALF) || ((center + HALF) >= pre_ext);
  assign single  = samp_single || cfg_err;
  assign first   = single ? center : center - HALF;
  assign last    = single ? center : center + HALF;
endmodule

// File: rtl/uart_rx_oversample_voter.sv
// rtl/uart_rx_oversample_voter.sv - majority-vote data sampler for the UART receiver
module uart_rx_oversample_voter
  import uart_rx_pkg::*;
#(
  parameter int unsigned PRESCALE_WIDTH = PRESCALE_WIDTH_DEF,
  parameter int unsigned NUM_SAMPLES    = 3
) (
  input  logic                     CLK,
  input  logic                     RST,
  uart_rx_oversample_voter_if.slave bus
);
  localparam int unsigned CW = $clog2(NUM_SAMPLES + 1);

  if ((NUM_SAMPLES % 2) == 0 || NUM_SAMPLES < 1 || NUM_SAMPLES > 7) begin : g_bad_num_samples
    $error("NUM_SAMPLES must be odd and within 1..7");
  end

  logic [PRESCALE_WIDTH:0]   win_first;
  logic [PRESCALE_WIDTH:0]   win_last;
  logic [PRESCALE_WIDTH:0]   edg;
  logic                      win_illegal;
  logic                      win_single;
  logic [CW-1:0]             ones_cnt;
  logic [CW-1:0]             total;
  logic [CW-1:0]             vote_half;
  logic [CW-1:0]             n_eff;
  logic [PRESCALE_WIDTH-1:0] last_edg;
  logic                      last_vld;
  logic                      new_edg;
  logic                      sampled_bit_q;
  logic                      sample_valid_q;
  logic                      noise_flag_q;
  logic                      cfg_err_q;

  uart_rx_sample_window #(
    .PRESCALE_WIDTH (PRESCALE_WIDTH),
    .NUM_SAMPLES    (NUM_SAMPLES)
  ) u_window (
    .prescale    (bus.PRESCALE),
    .samp_single (samp_mode_e'(bus.SAMP_MODE) == SAMP_SINGLE),
    .first       (win_first),
    .last        (win_last),
    .cfg_err     (win_illegal),
    .single      (win_single)
  );

  assign edg       = {1'b0, bus.EDG_CNT};
  // An edge count held over several cycles is acted on only in its first cycle.
  assign new_edg   = !last_vld || (bus.EDG_CNT != last_edg);
  assign total     = ones_cnt + CW'(bus.RX_IN);
  assign n_eff     = win_single ? CW'(1) : CW'(NUM_SAMPLES);
  assign vote_half = win_single ? '0 : CW'(maj_half(NUM_SAMPLES));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ones_cnt       <= '0;
      last_edg       <= '0;
      last_vld       <= 1'b0;
      sampled_bit_q  <= 1'b0;
      sample_valid_q <= 1'b0;
      noise_flag_q   <= 1'b0;
      cfg_err_q      <= 1'b0;
    end else if (!bus.DAT_SAMP_EN) begin
      ones_cnt       <= '0;
      last_vld       <= 1'b0;
      sampled_bit_q  <= 1'b0;
      sample_valid_q <= 1'b0;
      noise_flag_q   <= 1'b0;
      cfg_err_q      <= 1'b0;
    end else begin
      last_edg       <= bus.EDG_CNT;
      last_vld       <= 1'b1;
      cfg_err_q      <= win_illegal;
      sample_valid_q <= 1'b0;
      if (new_edg) begin
        if (edg == win_last) begin
          sampled_bit_q  <= (total > vote_half);
          noise_flag_q   <= (total != '0) && (total != n_eff);
          sample_valid_q <= 1'b1;
          ones_cnt       <= '0;
        end else if (edg >= win_first && edg < win_last) begin
          ones_cnt <= total;
        end else if (edg < win_first) begin
          ones_cnt <= '0;
        end
      end
    end
  end

  assign bus.SAMPLED_BIT  = sampled_bit_q;
  assign bus.SAMPLE_VALID = sample_valid_q;
  assign bus.NOISE_FLAG   = noise_flag_q;
  assign bus.CFG_ERR      = cfg_err_q;
endmodule

// File: tb/tb_uart_rx_oversample_voter.sv
// tb/tb_uart_rx_oversample_voter.sv - three sampler instances (N=3,5,7) against a per-bit vote model
module tb_uart_rx_oversample_voter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [5:0] prescale;
  logic [5:0] edg;
  logic       en;
  logic       mode;
  logic [2:0] o_bit, o_vld, o_noise, o_err;
  int         ns[3] = '{3, 5, 7};
  int         n_tests = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  uart_rx_oversample_voter_if #(.PRESCALE_WIDTH(6)) if3 ();
  uart_rx_oversample_voter_if #(.PRESCALE_WIDTH(6)) if5 ();
  uart_rx_oversample_voter_if #(.PRESCALE_WIDTH(6)) if7 ();

  assign {if3.RX_IN, if3.PRESCALE, if3.EDG_CNT, if3.DAT_SAMP_EN, if3.SAMP_MODE} = {rx, prescale, edg, en, mode};
  assign {if5.RX_IN, if5.PRESCALE, if5.EDG_CNT, if5.DAT_SAMP_EN, if5.SAMP_MODE} = {rx, prescale, edg, en, mode};
  assign {if7.RX_IN, if7.PRESCALE, if7.EDG_CNT, if7.DAT_SAMP_EN, if7.SAMP_MODE} = {rx, prescale, edg, en, mode};
  assign o_bit   = {if7.SAMPLED_BIT,  if5.SAMPLED_BIT,  if3.SAMPLED_BIT};
  assign o_vld   = {if7.SAMPLE_VALID, if5.SAMPLE_VALID, if3.SAMPLE_VALID};
  assign o_noise = {if7.NOISE_FLAG,   if5.NOISE_FLAG,   if3.NOISE_FLAG};
  assign o_err   = {if7.CFG_ERR,      if5.CFG_ERR,      if3.CFG_ERR};

  uart_rx_oversample_voter #(.PRESCALE_WIDTH(6), .NUM_SAMPLES(3)) dut3 (.CLK(clk), .RST(rst_n), .bus(if3.slave));
  uart_rx_oversample_voter #(.PRESCALE_WIDTH(6), .NUM_SAMPLES(5)) dut5 (.CLK(clk), .RST(rst_n), .bus(if5.slave));
  uart_rx_oversample_voter #(.PRESCALE_WIDTH(6), .NUM_SAMPLES(7)) dut7 (.CLK(clk), .RST(rst_n), .bus(if7.slave));

  task automatic check(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Whole-bit model: pick the window from the centre, count ones, vote.
  task automatic model(input int n, input int p, input logic m, input logic [63:0] rv,
                       output int hi, output logic b, output logic nz, output logic er);
    int half, c, lo, cnt;
    half = (n - 1) / 2;
    c    = p / 2;
    er   = (c < half) || (c + half > p - 1);
    lo   = (m || er) ? c : c - half;
    hi   = (m || er) ? c : c + half;
    cnt  = 0;
    for (int i = lo; i <= hi; i++) cnt += int'(rv[i]);
    b  = (2 * cnt > hi - lo + 1);
    nz = (cnt != 0) && (cnt != hi - lo + 1);
  endtask

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s_N%0d_bit", tag, ns[k]),   o_bit[k],   1'b0);
      check($sformatf("%s_N%0d_vld", tag, ns[k]),   o_vld[k],   1'b0);
      check($sformatf("%s_N%0d_noise", tag, ns[k]), o_noise[k], 1'b0);
      check($sformatf("%s_N%0d_err", tag, ns[k]),   o_err[k],   1'b0);
    end
  endtask

  task automatic drive_seq(input int p, input logic m, input logic [63:0] rv,
                           input int hold_pos, input int hold_n);
    int   hi[3];
    logic eb[3], enz[3], ee[3];
    for (int k = 0; k < 3; k++) model(ns[k], p, m, rv, hi[k], eb[k], enz[k], ee[k]);
    for (int e = 0; e < p; e++) begin
      for (int r = 0; r < ((e == hold_pos) ? hold_n : 1); r++) begin
        edg = 6'(e); rx = rv[e]; prescale = 6'(p); mode = m; en = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
          check($sformatf("N%0d_p%0d_e%0d_r%0d_vld", ns[k], p, e, r), o_vld[k], (e == hi[k] && r == 0));
          if (e == hi[k] && r == 0) begin
            check($sformatf("N%0d_p%0d_m%0b_bit", ns[k], p, m),   o_bit[k],   eb[k]);
            check($sformatf("N%0d_p%0d_m%0b_noise", ns[k], p, m), o_noise[k], enz[k]);
            check($sformatf("N%0d_p%0d_m%0b_err", ns[k], p, m),   o_err[k],   ee[k]);
          end
        end
      end
    end
  endtask

  task automatic idle(input int cycles);
    en = 1'b0;
    repeat (cycles) begin
      @(posedge clk); #1;
      check_all_zero("idle");
    end
  endtask

  initial begin
    logic [63:0] rv;
    rst_n = 1'b0; en = 1'b0; rx = 1'b0; edg = '0; prescale = 6'd16; mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    idle(1);

    rv = {$urandom, $urandom}; rv[9:7] = 3'b101; drive_seq(16, 1'b0, rv, -1, 1);
    rv = {$urandom, $urandom}; rv[9:7] = 3'b100; drive_seq(16, 1'b0, rv, -1, 1);
    rv = {$urandom, $urandom}; rv[9:7] = 3'b111; drive_seq(16, 1'b0, rv, -1, 1);
    rv = {$urandom, $urandom}; rv[10:6] = 5'b10001; drive_seq(16, 1'b0, rv, -1, 1);
    rv = {$urandom, $urandom}; rv[10:6] = 5'b00111; drive_seq(16, 1'b0, rv, -1, 1);

    idle(1);
    drive_seq(8, 1'b1, 64'h10, -1, 1);
    idle(1);
    rv = {$urandom, $urandom}; rv[2] = 1'b1; drive_seq(4, 1'b0, rv, -1, 1);

    idle(1);
    drive_seq(16, 1'b0, '1, -1, 1);
    for (int e = 0; e < 8; e++) begin
      edg = 6'(e); rx = 1'b1; en = 1'b1;
      @(posedge clk); #1;
    end
    edg = 6'd8;
    idle(2);
    drive_seq(16, 1'b0, '1, -1, 1);

    for (int e = 0; e < 8; e++) begin
      edg = 6'(e); rx = 1'b1; en = 1'b1;
      @(posedge clk); #1;
    end
    edg = 6'd8; rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(posedge clk); #1;
    check_all_zero("held_rst");
    rst_n = 1'b1;
    drive_seq(16, 1'b0, '1, -1, 1);
    rv = '0; rv[7] = 1'b1; drive_seq(16, 1'b0, rv, 7, 3);

    for (int t = 0; t < 25; t++) begin
      int   p, hp;
      logic m;
      p  = int'($urandom_range(2, 63));
      m  = ($urandom_range(0, 3) == 0);
      rv = {$urandom, $urandom};
      hp = int'($urandom_range(0, p - 1));
      idle(1);
      drive_seq(p, m, rv, hp, int'($urandom_range(1, 3)));
      drive_seq(p, m, ~rv, -1, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
